// File: rtl/spi_pkg.sv
// Shared SPI command constants and the draw-entry layout handed to the renderer.
package spi_pkg;

  localparam logic [7:0] COMMAND_SAVE_SPRITE = 8'h01;
  localparam logic [7:0] COMMAND_DRAW_SPRITE = 8'h02;
  localparam int         SPRITE_BYTES        = 512;

  typedef struct packed {
    logic [7:0]  sprite_id;
    logic [15:0] x;
    logic [15:0] y;
    logic [7:0]  flags;
  } draw_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; head is visible the cycle after a push (no bypass).
// A push while full is accepted only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the low bits match.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]) && (wr_ptr[PW] != rd_ptr[PW]);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign head    = mem[rd_ptr[PW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/spi_command_executor.sv
// Turns decoded SPI payload bytes into sprite RAM writes (SAVE) and buffered draw entries (DRAW).
// Writes land 1 cycle after the byte; draw entries are pushed the cycle after byte 5.
module spi_command_executor
  import spi_pkg::*;
#(
  parameter int SPRITE_COUNT = 64,
  parameter int FIFO_DEPTH   = 8,
  parameter int ADDR_W       = $clog2(SPRITE_COUNT * SPRITE_BYTES)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              abort,
  input  logic              data_valid,
  input  logic [7:0]        command,
  input  logic [15:0]       data_index,
  input  logic [7:0]        data,
  output logic              spr_wr_en,
  output logic [ADDR_W-1:0] spr_wr_addr,
  output logic [7:0]        spr_wr_data,
  output logic              draw_valid,
  input  logic              draw_ready,
  output logic [47:0]       draw_entry,
  output logic              overflow,
  output logic              bad_id
);

  localparam int PIX_W = $clog2(SPRITE_BYTES);
  localparam int ID_W  = ADDR_W - PIX_W;

  localparam logic [1:0] IDLE        = 2'd0;
  localparam logic [1:0] SAVE_ACTIVE = 2'd1;
  localparam logic [1:0] DRAW_ASM    = 2'd2;
  localparam logic [1:0] PUSH        = 2'd3;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [ID_W-1:0]  save_id;
  logic             save_ok;
  logic [2:0]       draw_idx;
  logic [47:0]      asm_q;

  logic             byte_ok;
  logic             is_save;
  logic             is_draw;
  logic             idx_zero;
  logic             save_wr;
  logic             draw_step;
  logic [PIX_W-1:0] pix;
  logic             entry_ok;
  logic             push_attempt;
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  draw_entry_t      fifo_head;

  assign byte_ok   = data_valid & ~abort;
  assign is_save   = (command == COMMAND_SAVE_SPRITE);
  assign is_draw   = (command == COMMAND_DRAW_SPRITE);
  assign idx_zero  = (data_index == 16'd0);
  assign pix       = PIX_W'(data_index - 16'd1);
  assign save_wr   = byte_ok & is_save & (state == SAVE_ACTIVE) & save_ok & ~idx_zero
                   & (32'(data_index) <= SPRITE_BYTES);
  assign draw_step = byte_ok & is_draw & (state == DRAW_ASM) & (data_index == {13'd0, draw_idx});

  assign push_attempt = (state == PUSH);
  assign entry_ok     = (32'(asm_q[47:40]) < SPRITE_COUNT);
  assign fifo_pop     = draw_valid & draw_ready;
  assign fifo_push    = push_attempt & entry_ok & (~fifo_full | fifo_pop);

  // PUSH lasts one cycle but still accepts a new byte, so it behaves like IDLE for decoding.
  always_comb begin
    state_next = (state == PUSH) ? IDLE : state;
    if (abort) begin
      state_next = IDLE;
    end else if (data_valid) begin
      if (is_save && idx_zero) begin
        state_next = SAVE_ACTIVE;
      end else if (is_draw && idx_zero) begin
        state_next = DRAW_ASM;
      end else if (is_draw && state == DRAW_ASM) begin
        if (draw_step) state_next = (data_index == 16'd5) ? PUSH : DRAW_ASM;
        else           state_next = IDLE;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      save_id     <= '0;
      save_ok     <= 1'b0;
      draw_idx    <= 3'd0;
      asm_q       <= '0;
      spr_wr_en   <= 1'b0;
      spr_wr_addr <= '0;
      spr_wr_data <= 8'd0;
      overflow    <= 1'b0;
      bad_id      <= 1'b0;
    end else begin
      state     <= state_next;
      spr_wr_en <= save_wr;
      if (save_wr) begin
        spr_wr_addr <= {save_id, pix};
        spr_wr_data <= data;
      end

      if (abort) begin
        save_ok <= 1'b0;
      end else if (data_valid && is_save && idx_zero) begin
        save_id <= data[ID_W-1:0];
        save_ok <= (32'(data) < SPRITE_COUNT);
        if (32'(data) >= SPRITE_COUNT) bad_id <= 1'b1;
      end

      if (byte_ok && is_draw && (idx_zero || draw_step)) begin
        asm_q    <= {asm_q[39:0], data};
        draw_idx <= idx_zero ? 3'd1 : draw_idx + 3'd1;
      end

      if (push_attempt && !entry_ok) bad_id <= 1'b1;
      if (push_attempt && entry_ok && fifo_full && !fifo_pop) overflow <= 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH (48),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (asm_q),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign draw_valid = ~fifo_empty;
  assign draw_entry = draw_valid ? fifo_head : 48'd0;

endmodule

// File: tb/tb_spi_command_executor.sv
// Randomized and directed bench for spi_command_executor against a queue-based reference model.
module tb_spi_command_executor;
  import spi_pkg::*;

  localparam int DEPTH = 8;
  localparam logic [7:0] CMD_OTHER = 8'h5C;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        abort = 1'b0;
  logic        data_valid = 1'b0;
  logic [7:0]  command = 8'd0;
  logic [15:0] data_index = 16'd0;
  logic [7:0]  data = 8'd0;
  logic        draw_ready = 1'b0;
  logic        spr_wr_en;
  logic [14:0] spr_wr_addr;
  logic [7:0]  spr_wr_data;
  logic        draw_valid;
  logic [47:0] draw_entry;
  logic        overflow;
  logic        bad_id;

  spi_command_executor dut (
    .clock       (clock),
    .reset       (reset),
    .abort       (abort),
    .data_valid  (data_valid),
    .command     (command),
    .data_index  (data_index),
    .data        (data),
    .spr_wr_en   (spr_wr_en),
    .spr_wr_addr (spr_wr_addr),
    .spr_wr_data (spr_wr_data),
    .draw_valid  (draw_valid),
    .draw_ready  (draw_ready),
    .draw_entry  (draw_entry),
    .overflow    (overflow),
    .bad_id      (bad_id)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int wr_count = 0;
  bit rand_mode = 0;

  // Reference model: current command context plus a queue standing in for the FIFO.
  int          m_save_id;
  int          m_draw_next;
  logic [7:0]  m_b [6];
  bit          m_pend;
  logic [47:0] m_pend_e;
  logic [47:0] m_q [$];
  bit          m_pop;
  int          m_sz;
  logic        e_wr;
  logic [14:0] e_addr;
  logic [7:0]  e_data;
  logic        e_ovf;
  logic        e_bad;

  always @(posedge clock) begin
    if (reset) begin
      m_save_id = -1; m_draw_next = -1; m_pend = 0; m_q.delete();
      e_wr = 0; e_addr = 0; e_data = 0; e_ovf = 0; e_bad = 0;
    end else begin
      m_sz  = m_q.size();
      m_pop = (m_sz > 0) && draw_ready;
      if (m_pend) begin
        if (m_pend_e[47:40] >= 8'd64)        e_bad = 1;
        else if (m_sz == DEPTH && !m_pop)    e_ovf = 1;
        else                                 m_q.push_back(m_pend_e);
      end
      if (m_pop) void'(m_q.pop_front());
      m_pend = 0;
      e_wr   = 0;
      if (data_valid && !abort) begin
        if (command == COMMAND_SAVE_SPRITE) begin
          if (data_index == 0) begin
            m_save_id = int'(data); m_draw_next = -1;
            if (data >= 8'd64) e_bad = 1;
          end else if (m_save_id >= 0 && m_save_id < 64 && data_index <= 16'd512) begin
            e_wr = 1; e_addr = 15'(m_save_id * 512 + int'(data_index) - 1); e_data = data;
          end
        end else if (command == COMMAND_DRAW_SPRITE) begin
          if (data_index == 0) begin
            m_b[0] = data; m_draw_next = 1; m_save_id = -1;
          end else if (m_draw_next > 0) begin
            if (int'(data_index) == m_draw_next) begin
              m_b[m_draw_next] = data;
              if (m_draw_next == 5) begin
                m_pend = 1; m_draw_next = -1;
                m_pend_e = {m_b[0], m_b[1], m_b[2], m_b[3], m_b[4], m_b[5]};
              end else m_draw_next++;
            end else m_draw_next = -1;
          end
        end
      end
      if (abort) begin m_save_id = -1; m_draw_next = -1; end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    forever begin
      @(posedge clock); #1;
      chk("wr_en", spr_wr_en, e_wr);
      if (e_wr) begin
        chk("wr_addr", spr_wr_addr, e_addr);
        chk("wr_data", spr_wr_data, e_data);
      end
      chk("draw_valid", draw_valid, m_q.size() > 0);
      if (m_q.size() > 0) chk("draw_entry", draw_entry, m_q[0]);
      chk("overflow", overflow, e_ovf);
      chk("bad_id", bad_id, e_bad);
      if (spr_wr_en) wr_count++;
    end
  endtask

  task automatic send(input logic [7:0] cmd, input int idx, input logic [7:0] d);
    command = cmd; data_index = 16'(idx); data = d; data_valid = 1'b1;
    if (rand_mode) begin
      draw_ready = 1'($urandom_range(0, 1));
      abort = ($urandom_range(0, 40) == 0);
    end
    @(negedge clock);
    data_valid = 1'b0; abort = 1'b0;
  endtask

  task automatic send_draw(input logic [7:0] id, input logic [15:0] x, input logic [15:0] y,
                           input logic [7:0] f);
    send(COMMAND_DRAW_SPRITE, 0, id);
    send(COMMAND_DRAW_SPRITE, 1, x[15:8]);
    send(COMMAND_DRAW_SPRITE, 2, x[7:0]);
    send(COMMAND_DRAW_SPRITE, 3, y[15:8]);
    send(COMMAND_DRAW_SPRITE, 4, y[7:0]);
    send(COMMAND_DRAW_SPRITE, 5, f);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic logic [47:0] mk(input int k);
    return {8'(k), 16'(k * 256 + 3), 16'(16'hFF00 - k), 8'(k) ^ 8'h5A};
  endfunction

  task automatic main_seq();
    int base;
    int n;
    int idx;
    logic [47:0] e;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_wr_en", spr_wr_en, 0);
    chk("rst_valid", draw_valid, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_bad", bad_id, 0);

    // SAVE id 3, full sprite
    base = wr_count;
    send(COMMAND_SAVE_SPRITE, 0, 8'd3);
    for (int i = 1; i <= 512; i++) begin
      send(COMMAND_SAVE_SPRITE, i, 8'(i - 1));
      if (i == 1) begin
        chk("save_first_en", spr_wr_en, 1);
        chk("save_first_addr", spr_wr_addr, 15'h0600);
        chk("save_first_data", spr_wr_data, 8'h00);
      end
      if (i == 512) begin
        chk("save_last_addr", spr_wr_addr, 15'h07FF);
        chk("save_last_data", spr_wr_data, 8'hFF);
      end
    end
    send(COMMAND_SAVE_SPRITE, 513, 8'h11);
    chk("save_count", wr_count - base, 512);

    // Single DRAW, renderer ready
    draw_ready = 1'b1;
    send_draw(8'd5, 16'h0140, 16'hFFF0, 8'h81);
    chk("draw_no_bypass", draw_valid, 0);
    @(posedge clock); #1;
    chk("draw_valid_lit", draw_valid, 1);
    chk("draw_entry_lit", draw_entry, 48'h05_0140_FFF0_81);
    repeat (3) @(negedge clock);
    draw_ready = 1'b0;

    // 9 DRAWs into a depth-8 FIFO
    for (int k = 0; k < 9; k++) begin
      e = mk(k);
      send_draw(e[47:40], e[39:24], e[23:8], e[7:0]);
    end
    @(negedge clock);
    chk("ovf_set", overflow, 1);
    draw_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk("drain_valid", draw_valid, 1);
      chk("drain_entry", draw_entry, mk(k));
      @(negedge clock);
    end
    chk("drain_empty", draw_valid, 0);
    draw_ready = 1'b0;

    do_reset();
    chk("reset_clears_ovf", overflow, 0);

    // Full FIFO with simultaneous push and pop
    for (int k = 10; k < 18; k++) begin
      e = mk(k);
      send_draw(e[47:40], e[39:24], e[23:8], e[7:0]);
    end
    e = mk(18);
    send_draw(e[47:40], e[39:24], e[23:8], e[7:0]);
    draw_ready = 1'b1;
    @(negedge clock);
    draw_ready = 1'b0;
    chk("pushpop_no_ovf", overflow, 0);
    draw_ready = 1'b1;
    for (int k = 11; k <= 18; k++) begin
      chk("pushpop_valid", draw_valid, 1);
      chk("pushpop_entry", draw_entry, mk(k));
      @(negedge clock);
    end
    chk("pushpop_empty", draw_valid, 0);
    draw_ready = 1'b0;

    // Bad sprite ids
    do_reset();
    base = wr_count;
    send(COMMAND_SAVE_SPRITE, 0, 8'd70);
    for (int i = 1; i <= 4; i++) send(COMMAND_SAVE_SPRITE, i, 8'(i));
    chk("bad_save_no_wr", wr_count - base, 0);
    chk("bad_save_flag", bad_id, 1);
    do_reset();
    chk("reset_clears_bad", bad_id, 0);
    send_draw(8'd64, 16'h0001, 16'h0002, 8'h03);
    @(negedge clock);
    chk("bad_draw_flag", bad_id, 1);
    chk("bad_draw_no_push", draw_valid, 0);
    do_reset();

    // abort mid-DRAW, then a clean DRAW id 2
    send(COMMAND_DRAW_SPRITE, 0, 8'd9);
    send(COMMAND_DRAW_SPRITE, 1, 8'h11);
    send(COMMAND_DRAW_SPRITE, 2, 8'h22);
    send(COMMAND_DRAW_SPRITE, 3, 8'h33);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
    send(COMMAND_DRAW_SPRITE, 4, 8'h44);
    send(COMMAND_DRAW_SPRITE, 5, 8'h55);
    send_draw(8'd2, 16'h1234, 16'h5678, 8'h9A);
    @(negedge clock);
    chk("abort_valid", draw_valid, 1);
    chk("abort_entry", draw_entry, 48'h02_1234_5678_9A);
    draw_ready = 1'b1; @(negedge clock); draw_ready = 1'b0;
    chk("abort_single", draw_valid, 0);

    // abort invalidates the latched SAVE id
    base = wr_count;
    send(COMMAND_SAVE_SPRITE, 0, 8'd4);
    send(COMMAND_SAVE_SPRITE, 1, 8'hAA);
    abort = 1'b1; @(negedge clock); abort = 1'b0;
    send(COMMAND_SAVE_SPRITE, 2, 8'hBB);
    @(negedge clock);
    chk("abort_save_writes", wr_count - base, 1);

    // Randomized traffic
    rand_mode = 1;
    for (int t = 0; t < 400; t++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: begin
          send(COMMAND_SAVE_SPRITE, 0, 8'($urandom_range(0, 70)));
          n = $urandom_range(0, 12);
          for (int j = 1; j <= n; j++) send(COMMAND_SAVE_SPRITE, j, 8'($urandom));
          if ($urandom_range(0, 3) == 0)
            for (int j = 510; j <= 514; j++) send(COMMAND_SAVE_SPRITE, j, 8'($urandom));
        end
        4, 5, 6, 7: begin
          for (int j = 0; j < 6; j++) begin
            idx = j;
            if ($urandom_range(0, 15) == 0) idx = $urandom_range(0, 7);
            send(COMMAND_DRAW_SPRITE, idx, (j == 0) ? 8'($urandom_range(0, 68)) : 8'($urandom));
          end
        end
        default: send(CMD_OTHER, $urandom_range(0, 6), 8'($urandom));
      endcase
      repeat ($urandom_range(0, 3)) begin
        draw_ready = 1'($urandom_range(0, 1));
        abort = ($urandom_range(0, 20) == 0);
        @(negedge clock);
        abort = 1'b0;
      end
    end
    rand_mode = 0;
    draw_ready = 1'b1;
    repeat (12) @(negedge clock);
  endtask

  initial begin
    fork
      compare_loop();
      main_seq();
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
